// File: rtl/avalon_mm_cmd_master.sv
// avalon_mm_cmd_master
// Converts a valid/ready command stream into single Avalon-MM read or write
// transactions. At most one transaction is in flight. A stalled slave is
// abandoned after TIMEOUT bus-phase cycles. The result is held in a response
// buffer until the consumer takes it.

module avalon_mm_cmd_master #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,

  output logic [ADDR_W-1:0] avm_m0_address,
  output logic              avm_m0_read,
  output logic              avm_m0_write,
  output logic [DATA_W-1:0] avm_m0_writedata,
  input  logic [DATA_W-1:0] avm_m0_readdata,
  input  logic              avm_m0_waitrequest,
  input  logic              avm_m0_readdatavalid
);

  // The counter must be able to hold TIMEOUT itself so it can saturate there
  // or above without wrapping back into the abort comparison.
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_REQ  = 3'd2,
    READ_WAIT = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic                r_cmdReady;
  logic                r_rspValid;
  logic [DATA_W-1:0]   r_rspReaddata;
  logic                r_rspError;
  logic [ADDR_W-1:0]   r_avmAddress;
  logic [DATA_W-1:0]   r_avmWritedata;
  logic                r_avmRead;
  logic                r_avmWrite;
  logic [CNT_W-1:0]    r_count;

  logic                w_accept;
  logic                w_inBusPhase;
  logic                w_timeoutHit;
  logic                w_nextRead;
  logic                w_nextWrite;
  logic                w_loadRsp;
  logic                w_clearRsp;
  logic [DATA_W-1:0]   w_nextRspData;
  logic                w_nextRspError;

  // A command is taken only while the ready flag is up, which keeps the
  // first cycle after reset release from accepting anything.
  assign w_accept     = (r_state == IDLE) && r_cmdReady && cmd_valid;
  assign w_inBusPhase = (r_state == WRITE) || (r_state == READ_REQ) ||
                        (r_state == READ_WAIT);
  assign w_timeoutHit = (r_count == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus the next values of the bus request strobes and the
  // response buffer; a phase that completes in the abort cycle still wins.
  always_comb begin
    w_nextState    = r_state;
    w_nextRead     = r_avmRead;
    w_nextWrite    = r_avmWrite;
    w_loadRsp      = 1'b0;
    w_clearRsp     = 1'b0;
    w_nextRspData  = '0;
    w_nextRspError = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = cmd_write ? WRITE : READ_REQ;
          w_nextWrite = cmd_write;
          w_nextRead  = !cmd_write;
        end
      end

      WRITE: begin
        if (!avm_m0_waitrequest) begin
          w_nextState = RESP;
          w_nextWrite = 1'b0;
          w_loadRsp   = 1'b1;
        end else if (w_timeoutHit) begin
          w_nextState    = RESP;
          w_nextWrite    = 1'b0;
          w_loadRsp      = 1'b1;
          w_nextRspError = 1'b1;
        end
      end

      READ_REQ: begin
        if (!avm_m0_waitrequest && avm_m0_readdatavalid) begin
          w_nextState   = RESP;
          w_nextRead    = 1'b0;
          w_loadRsp     = 1'b1;
          w_nextRspData = avm_m0_readdata;
        end else if (w_timeoutHit) begin
          w_nextState    = RESP;
          w_nextRead     = 1'b0;
          w_loadRsp      = 1'b1;
          w_nextRspError = 1'b1;
        end else if (!avm_m0_waitrequest) begin
          w_nextState = READ_WAIT;
          w_nextRead  = 1'b0;
        end
      end

      READ_WAIT: begin
        if (avm_m0_readdatavalid) begin
          w_nextState   = RESP;
          w_loadRsp     = 1'b1;
          w_nextRspData = avm_m0_readdata;
        end else if (w_timeoutHit) begin
          w_nextState    = RESP;
          w_loadRsp      = 1'b1;
          w_nextRspError = 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          w_nextState = IDLE;
          w_clearRsp  = 1'b1;
        end
      end

      default: begin
        w_nextState = IDLE;
        w_nextRead  = 1'b0;
        w_nextWrite = 1'b0;
      end
    endcase
  end

  // Ready is registered: it rises the cycle after the FSM settles in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmdReady <= 1'b0;
    end else begin
      r_cmdReady <= (w_nextState == IDLE);
    end
  end

  // Bus-phase cycle counter: cleared on accept, counts while a transaction
  // occupies the bus, and saturates so it can never wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= '0;
    end else if (w_inBusPhase && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Read/write strobes; reset drops them asynchronously mid-transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_avmRead  <= 1'b0;
      r_avmWrite <= 1'b0;
    end else begin
      r_avmRead  <= w_nextRead;
      r_avmWrite <= w_nextWrite;
    end
  end

  // Address and write data are captured once per command and held stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_avmAddress   <= '0;
      r_avmWritedata <= '0;
    end else if (w_accept) begin
      r_avmAddress   <= cmd_address;
      r_avmWritedata <= cmd_writedata;
    end
  end

  // Response buffer: loaded when the transaction ends, emptied on handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rspValid    <= 1'b0;
      r_rspReaddata <= '0;
      r_rspError    <= 1'b0;
    end else if (w_loadRsp) begin
      r_rspValid    <= 1'b1;
      r_rspReaddata <= w_nextRspData;
      r_rspError    <= w_nextRspError;
    end else if (w_clearRsp) begin
      r_rspValid    <= 1'b0;
      r_rspReaddata <= '0;
      r_rspError    <= 1'b0;
    end
  end

  assign cmd_ready        = r_cmdReady;
  assign rsp_valid        = r_rspValid;
  assign rsp_readdata     = r_rspReaddata;
  assign rsp_error        = r_rspError;
  assign avm_m0_address   = r_avmAddress;
  assign avm_m0_read      = r_avmRead;
  assign avm_m0_write     = r_avmWrite;
  assign avm_m0_writedata = r_avmWritedata;

endmodule

// File: tb/tb_avalon_mm_cmd_master.sv
// tb_avalon_mm_cmd_master
// Drives commands, plays an Avalon slave and a response consumer, and keeps a
// transaction-level model: for each accepted command the bench works out,
// from the slave delays it chose, how many bus cycles the request lasts, when
// the response appears and what it carries.

module tb_avalon_mm_cmd_master;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int MAXID = 512;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_address;
  logic [DW-1:0] cmd_writedata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_readdata;
  logic          rsp_error;
  logic [AW-1:0] avm_m0_address;
  logic          avm_m0_read;
  logic          avm_m0_write;
  logic [DW-1:0] avm_m0_writedata;
  logic [DW-1:0] avm_m0_readdata;
  logic          avm_m0_waitrequest;
  logic          avm_m0_readdatavalid;

  avalon_mm_cmd_master #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_write           (cmd_write),
    .cmd_address         (cmd_address),
    .cmd_writedata       (cmd_writedata),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_readdata        (rsp_readdata),
    .rsp_error           (rsp_error),
    .avm_m0_address      (avm_m0_address),
    .avm_m0_read         (avm_m0_read),
    .avm_m0_write        (avm_m0_write),
    .avm_m0_writedata    (avm_m0_writedata),
    .avm_m0_readdata     (avm_m0_readdata),
    .avm_m0_waitrequest  (avm_m0_waitrequest),
    .avm_m0_readdatavalid(avm_m0_readdatavalid)
  );

  always #5 clk = ~clk;

  // One command plus the slave behaviour it will meet: waitN waitrequest
  // cycles, then readdatavalid delay cycles after the request is taken.
  typedef struct {
    int            id;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waitN;
    int            delay;
    logic [DW-1:0] rdata;
    int            hold;
    int            gap;
  } cmd_t;

  cmd_t          cmdQ[$];
  cmd_t          cur;
  cmd_t          nxt;
  bit            busy;
  bit            presenting;
  bit            notReady;
  bit            ok;
  int            j;
  int            act;
  int            respStart;
  int            complCycle;
  int            gapLeft;
  logic [AW-1:0] lastAddr;
  logic [DW-1:0] lastWdata;
  bit            eRead;
  bit            eWrite;
  bit            eRspValid;
  bit            eCmdReady;
  int            cyc;
  int            checks;
  int            failures;
  int            nextId;

  int            accCyc [MAXID];
  int            hsCyc  [MAXID];
  int            obsAct [MAXID];
  int            obsRsp [MAXID];
  logic [DW-1:0] obsData[MAXID];
  logic          obsErr [MAXID];

  task automatic chkBit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  task automatic chkWord(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic chkInt(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic pushCmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waitN, input int delay, input logic [DW-1:0] rdata,
                         input int hold, input int gap, output int id);
    cmd_t c;
    c.id    = nextId;
    c.wr    = wr;
    c.addr  = addr;
    c.wdata = wdata;
    c.waitN = waitN;
    c.delay = delay;
    c.rdata = rdata;
    c.hold  = hold;
    c.gap   = gap;
    id      = nextId;
    accCyc[nextId]  = -1;
    hsCyc[nextId]   = -1;
    obsAct[nextId]  = 0;
    obsRsp[nextId]  = -1;
    obsData[nextId] = '0;
    obsErr[nextId]  = 1'b0;
    nextId++;
    cmdQ.push_back(c);
  endtask

  // Compare every DUT output with what the transaction model says for this cycle.
  task automatic checkOutput();
    if (busy) begin
      eWrite    = cur.wr && (j <= act);
      eRead     = !cur.wr && (j <= act);
      eRspValid = (j >= respStart);
      eCmdReady = 1'b0;
    end else begin
      eWrite    = 1'b0;
      eRead     = 1'b0;
      eRspValid = 1'b0;
      eCmdReady = !notReady;
    end
    chkBit("avm_write", avm_m0_write, eWrite);
    chkBit("avm_read", avm_m0_read, eRead);
    chkBit("rd_wr_exclusive", avm_m0_read & avm_m0_write, 1'b0);
    chkBit("rsp_valid", rsp_valid, eRspValid);
    chkBit("cmd_ready", cmd_ready, eCmdReady);
    chkWord("avm_address", DW'(avm_m0_address), DW'(lastAddr));
    chkWord("avm_writedata", avm_m0_writedata, lastWdata);
    if (eRspValid) begin
      chkWord("rsp_readdata", rsp_readdata, (ok && !cur.wr) ? cur.rdata : '0);
      chkBit("rsp_error", rsp_error, !ok);
    end
    if (busy) begin
      if (avm_m0_read || avm_m0_write) obsAct[cur.id]++;
      if (rsp_valid === 1'b1 && obsRsp[cur.id] < 0) begin
        obsRsp[cur.id]  = j;
        obsData[cur.id] = rsp_readdata;
        obsErr[cur.id]  = rsp_error;
      end
    end
  endtask

  // Drive command, slave and consumer inputs for the current cycle.
  task automatic applyStimulus();
    if (!presenting && cmdQ.size() > 0) begin
      nxt        = cmdQ.pop_front();
      presenting = 1'b1;
      gapLeft    = nxt.gap;
    end
    if (presenting && gapLeft == 0) begin
      cmd_valid     = 1'b1;
      cmd_write     = nxt.wr;
      cmd_address   = nxt.addr;
      cmd_writedata = nxt.wdata;
    end else begin
      cmd_valid     = 1'b0;
      cmd_write     = 1'($urandom);
      cmd_address   = AW'($urandom);
      cmd_writedata = $urandom;
      if (presenting) gapLeft--;
    end

    avm_m0_waitrequest   = 1'($urandom);
    avm_m0_readdatavalid = ($urandom_range(0, 3) == 0);
    avm_m0_readdata      = $urandom;
    rsp_ready            = 1'($urandom);
    if (busy) begin
      if (j <= act) avm_m0_waitrequest = (j <= cur.waitN);
      if (!cur.wr && j < respStart) begin
        avm_m0_readdatavalid = ok && (j == complCycle);
        if (avm_m0_readdatavalid) avm_m0_readdata = cur.rdata;
      end
      if (j >= respStart) rsp_ready = (j >= respStart + cur.hold);
    end
  endtask

  // Advance the model across the coming rising edge.
  task automatic advanceModel();
    if (busy) begin
      if (j >= respStart && rsp_ready) begin
        hsCyc[cur.id] = cyc;
        busy = 1'b0;
      end else begin
        j++;
      end
    end else if (cmd_valid && eCmdReady) begin
      cur        = nxt;
      presenting = 1'b0;
      busy       = 1'b1;
      j          = 1;
      complCycle = cur.wr ? cur.waitN + 1 : cur.waitN + 1 + cur.delay;
      ok         = (complCycle <= TO);
      act        = (cur.waitN + 1 < TO) ? cur.waitN + 1 : TO;
      respStart  = (ok ? complCycle : TO) + 1;
      lastAddr   = cur.addr;
      lastWdata  = cur.wdata;
      accCyc[cur.id] = cyc;
    end
    notReady = 1'b0;
  endtask

  task automatic runLoop(input int maxCycles, input bit untilDone);
    for (int n = 0; n < maxCycles; n++) begin
      if (untilDone && !busy && !presenting && cmdQ.size() == 0) return;
      checkOutput();
      applyStimulus();
      advanceModel();
      @(negedge clk);
      cyc++;
    end
    if (untilDone) begin
      checks++;
      if (busy || presenting || cmdQ.size() > 0) begin
        failures++;
        $display("[TB] FAIL run_bound cycle=%0d got=unfinished expected=drained", cyc);
      end
    end
  endtask

  // Reset pulse from the middle of a cycle: the request must drop at once.
  task automatic pulseReset();
    #2 reset_n = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chkBit("mid_rst_read", avm_m0_read, 1'b0);
    chkBit("mid_rst_write", avm_m0_write, 1'b0);
    chkBit("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chkBit("mid_rst_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    chkWord("mid_rst_address", DW'(avm_m0_address), '0);
    chkWord("mid_rst_rsp_readdata", rsp_readdata, '0);
    busy       = 1'b0;
    presenting = 1'b0;
    notReady   = 1'b1;
    lastAddr   = '0;
    lastWdata  = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idW0, idW3, idRd, idTo, idNext, idHold, idPend, idEdge, idOver, idRst0, idRst1, idPost, dummy;
    int r;
    int rw;
    int rd;

    checks = 0; failures = 0; cyc = 0; nextId = 0;
    busy = 1'b0; presenting = 1'b0; notReady = 1'b1; ok = 1'b0;
    j = 0; act = 0; respStart = 0; complCycle = 0; gapLeft = 0;
    lastAddr = '0; lastWdata = '0;
    reset_n = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 4'h5; cmd_writedata = 32'h1111_2222;
    rsp_ready = 1'b1; avm_m0_waitrequest = 1'b0; avm_m0_readdatavalid = 1'b1;
    avm_m0_readdata = 32'hDEAD_BEEF;
    #1 reset_n = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chkBit("rst_cmd_ready", cmd_ready, 1'b0);
      chkBit("rst_rsp_valid", rsp_valid, 1'b0);
      chkBit("rst_rsp_error", rsp_error, 1'b0);
      chkWord("rst_rsp_readdata", rsp_readdata, '0);
      chkBit("rst_avm_read", avm_m0_read, 1'b0);
      chkBit("rst_avm_write", avm_m0_write, 1'b0);
      chkWord("rst_avm_address", DW'(avm_m0_address), '0);
      chkWord("rst_avm_writedata", avm_m0_writedata, '0);
    end
    reset_n   = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chkBit("first_clock_cmd_ready", cmd_ready, 1'b1);
    notReady = 1'b0;

    $display("[TB] directed transactions");
    pushCmd(1'b1, 4'h0, 32'h0ABC_DEF0, 0, 0, '0, 0, 0, idW0);
    pushCmd(1'b1, 4'hA, 32'h1234_5678, 3, 0, '0, 0, 0, idW3);
    pushCmd(1'b0, 4'h3, 32'h0, 0, 1, 32'h0FFF_FFFF, 0, 0, idRd);
    pushCmd(1'b0, 4'h7, 32'h0, 1000, 0, 32'h5555_AAAA, 0, 0, idTo);
    pushCmd(1'b0, 4'h7, 32'h0, 0, 0, 32'hCAFE_0001, 0, 0, idNext);
    pushCmd(1'b1, 4'h2, 32'h0000_00C8, 0, 0, '0, 5, 0, idHold);
    pushCmd(1'b0, 4'h1, 32'h0, 2, 0, 32'h1357_9BDF, 0, 0, idPend);
    pushCmd(1'b1, 4'hF, 32'hFFFF_0000, TO - 1, 0, '0, 0, 1, idEdge);
    pushCmd(1'b1, 4'hE, 32'h00FF_00FF, TO, 0, '0, 0, 0, idOver);
    runLoop(2000, 1'b1);

    chkInt("w0_active_cycles", obsAct[idW0], 1);
    chkInt("w0_rsp_offset", obsRsp[idW0], 2);
    chkWord("w0_rsp_readdata", obsData[idW0], 32'h0);
    chkBit("w0_rsp_error", obsErr[idW0], 1'b0);
    chkInt("back_to_back_spacing", accCyc[idW3] - accCyc[idW0], 3);
    chkInt("w3_active_cycles", obsAct[idW3], 4);
    chkInt("w3_rsp_offset", obsRsp[idW3], 5);
    chkInt("rd_active_cycles", obsAct[idRd], 1);
    chkInt("rd_rsp_offset", obsRsp[idRd], 3);
    chkWord("rd_rsp_readdata", obsData[idRd], 32'h0FFF_FFFF);
    chkBit("rd_rsp_error", obsErr[idRd], 1'b0);
    chkInt("to_active_cycles", obsAct[idTo], 8);
    chkInt("to_rsp_offset", obsRsp[idTo], 9);
    chkBit("to_rsp_error", obsErr[idTo], 1'b1);
    chkWord("to_rsp_readdata", obsData[idTo], 32'h0);
    chkWord("after_to_readdata", obsData[idNext], 32'hCAFE_0001);
    chkBit("after_to_error", obsErr[idNext], 1'b0);
    chkInt("hold_handshake_offset", hsCyc[idHold] - accCyc[idHold], 7);
    chkInt("pending_accept_after_hs", accCyc[idPend] - hsCyc[idHold], 1);
    chkWord("pending_readdata", obsData[idPend], 32'h1357_9BDF);
    chkInt("edge_active_cycles", obsAct[idEdge], 8);
    chkBit("edge_rsp_error", obsErr[idEdge], 1'b0);
    chkInt("over_active_cycles", obsAct[idOver], 8);
    chkBit("over_rsp_error", obsErr[idOver], 1'b1);

    $display("[TB] reset during READ_REQ and READ_WAIT");
    pushCmd(1'b0, 4'h9, 32'h0, 1000, 0, 32'h0, 0, 0, idRst0);
    runLoop(4, 1'b0);
    chkBit("pre_rst_read_high", avm_m0_read, 1'b1);
    pulseReset();
    runLoop(3, 1'b0);
    pushCmd(1'b0, 4'h6, 32'h0, 0, 100, 32'h0, 0, 0, idRst1);
    runLoop(3, 1'b0);
    chkBit("pre_rst_wait_read_low", avm_m0_read, 1'b0);
    pulseReset();
    pushCmd(1'b1, 4'h4, 32'h0BAD_F00D, 1, 0, '0, 0, 0, dummy);
    pushCmd(1'b0, 4'h4, 32'h0, 0, 0, 32'h0BAD_F00D, 0, 0, idPost);
    runLoop(200, 1'b1);
    chkInt("post_rst_rsp_offset", obsRsp[idPost], 2);
    chkWord("post_rst_readdata", obsData[idPost], 32'h0BAD_F00D);
    chkInt("rst0_no_response", obsRsp[idRst0], -1);

    $display("[TB] randomized transactions");
    for (int k = 0; k < 120; k++) begin
      r  = $urandom_range(0, 9);
      rw = (r < 6) ? int'($urandom_range(0, 2)) : ((r < 9) ? int'($urandom_range(3, 7)) : int'($urandom_range(8, 12)));
      r  = $urandom_range(0, 9);
      rd = (r < 6) ? int'($urandom_range(0, 2)) : ((r < 9) ? int'($urandom_range(3, 6)) : int'($urandom_range(7, 10)));
      pushCmd(1'($urandom), AW'($urandom), $urandom, rw, rd, $urandom,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, dummy);
    end
    runLoop(20000, 1'b1);
    runLoop(5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_mm_cmd_master.md
# avalon_mm_cmd_master

Avalon-MM master that turns a simple command stream into single bus transactions on the peripheral fabric, such as writing a prescaler value or reading it back. It sits between a sequencer or soft-logic controller and memory-mapped slaves like the prescaler register block. It has at most one transaction outstanding, a timeout on stalled slaves, and a held response buffer with valid/ready handshake.

## Interface
- ADDR_W, default 4, width of command and bus address.
- DATA_W, default 32, width of write/read data.
- TIMEOUT, default 255, maximum bus-phase cycles before abort; legal range 1..65535.
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when valid&ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  ADDR_W  target address.
- cmd_writedata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer takes response.
- rsp_readdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_error  out  1  1 = transaction timed out.
- avm_m0_address  out  ADDR_W  bus address.
- avm_m0_read  out  1  bus read request.
- avm_m0_write  out  1  bus write request.
- avm_m0_writedata  out  DATA_W  bus write data.
- avm_m0_readdata  in  DATA_W  bus read data; sampled only on readdatavalid.
- avm_m0_waitrequest  in  1  slave stall.
- avm_m0_readdatavalid  in  1  read data valid.

## Operation
- Reset state, asynchronous on reset_n low:
  - state IDLE.
  - cmd_ready=0 while reset_n is low.
  - rsp_valid=0, rsp_error=0, rsp_readdata=0.
  - avm_m0_read=0, avm_m0_write=0, avm_m0_address=0, avm_m0_writedata=0.
  - timeout counter=0.
- FSM: IDLE, WRITE, READ_REQ, READ_WAIT, RESP.
- IDLE
  - cmd_ready=1.
  - On cmd_valid: latch address and writedata into the avm_m0_* registers.
  - Go to WRITE if cmd_write=1, else READ_REQ. Clear the counter.
- WRITE
  - avm_m0_write=1; address and writedata held stable.
  - On a cycle with waitrequest=0: deassert write next cycle, load rsp_readdata=0 and rsp_error=0, go to RESP.
- READ_REQ
  - avm_m0_read=1, address stable.
  - On waitrequest=0 with readdatavalid=1 in the same cycle: capture readdata and go to RESP.
  - On waitrequest=0 with readdatavalid=0: go to READ_WAIT.
- READ_WAIT
  - avm_m0_read=0.
  - On readdatavalid=1: capture readdata, rsp_error=0, go to RESP.
- Timeout
  - The counter increments every cycle in WRITE, READ_REQ and READ_WAIT; width is $clog2(TIMEOUT+1), saturating.
  - If the counter equals TIMEOUT-1 and the current phase is not completing this cycle: drop read/write, rsp_error=1, rsp_readdata=0, go to RESP.
  - Completion in that same cycle wins over timeout.
- RESP
  - rsp_valid=1; outputs held stable until rsp_ready=1, then go to IDLE.
  - cmd_ready=0 throughout RESP.
- readdatavalid arriving outside READ_REQ/READ_WAIT is ignored.
- avm_m0_read and avm_m0_write are never asserted together.

## Timing
- All outputs are registered.
- Command accepted at edge N → avm_m0_read or avm_m0_write high from cycle N+1.
- Zero-wait write
  - write high for exactly 1 cycle.
  - rsp_valid rises at N+2.
  - cmd_ready returns the cycle after the rsp handshake.
- Zero-wait read with same-cycle readdatavalid: rsp_valid at N+2 with captured data.
- Each waitrequest cycle or readdatavalid delay cycle adds 1 cycle.
- Minimum command-to-command throughput: 1 command per 3 cycles when rsp_ready is held high.
- Reset mid-transaction aborts immediately with no response; the bus request drops asynchronously.

## Test plan
- Reset held low with cmd_valid=1 → all outputs 0, no bus activity; after release, cmd_ready=1 on the first clock.
- Write addr 0, data 0x0ABCDEF0, waitrequest=0 → one write cycle at N+1 with addr 0, data 0x0ABCDEF0; rsp_valid at N+2, rsp_error=0, rsp_readdata=0.
- Write with waitrequest high 3 cycles → write held 4 cycles, address and data stable; rsp after release.
- Read, slave returns 0x0FFFFFFF with readdatavalid 2 cycles after accept → read high 1 cycle; rsp_readdata=0x0FFFFFFF, rsp_error=0.
- TIMEOUT=8, waitrequest stuck high → read drops after 8 cycles; rsp_error=1, rsp_readdata=0; the next command works normally.
- rsp_ready held low 5 cycles with a new cmd_valid pending → rsp fields stable, cmd_ready=0; the command is accepted the cycle after the handshake.
- reset_n pulsed low while in READ_WAIT → avm_m0_read=0 and rsp_valid=0 immediately; FSM returns to IDLE.
